pdp8_mem_unit: RTL and testbench
================================

Name: pdp8_mem_unit

Overview:
Memory responder for the PDP-8 core. It services IFD instruction fetches and EXEC operand reads/writes from a 4K x 12 word store, and it sits on the far side of the ifu_rd_req/ifu_rd_addr/ifu_rd_data interface. After reset it clears the array, accepts a program image through a loader port, and then enters normal service.

Parameters:
ADDR_WIDTH, 12, word address width (pkg `ADDR_WIDTH).
DATA_WIDTH, 12, word width (pkg `DATA_WIDTH).
CLEAR_ON_RESET, 1, 1 = sweep-clear the array after reset; 0 = skip straight to LOAD.

Ports:
clk  in  1  clock, all state updates on posedge.
reset_n  in  1  reset, asynchronous, active-high (asserted when reset_n=1).
load_wr  in  1  loader write strobe, honoured only in LOAD.
load_addr  in  ADDR_WIDTH  loader address.
load_data  in  DATA_WIDTH  loader data.
load_done  in  1  end-of-image pulse, LOAD->READY.
mem_ready  out  1  high only in READY.
ifu_rd_req  in  1  IFD fetch request.
ifu_rd_addr  in  ADDR_WIDTH  fetch address.
ifu_rd_data  out  DATA_WIDTH  fetched word.
exec_rd_req  in  1  EXEC operand read request.
exec_rd_addr  in  ADDR_WIDTH  operand read address.
exec_rd_data  out  DATA_WIDTH  operand word.
exec_wr_req  in  1  EXEC write request.
exec_wr_addr  in  ADDR_WIDTH  write address.
exec_wr_data  in  DATA_WIDTH  write data.
req_err  out  1  sticky: request seen while not READY.

Behaviour:
- Reset asserted: state=INIT (or LOAD if CLEAR_ON_RESET=0), clear counter=0, ifu_rd_data=0, exec_rd_data=0, mem_ready=0, req_err=0. Array contents are not reset directly.
- States: INIT, LOAD, READY.
- INIT: one word per cycle, writes 0 at address counter, counter+1. After address 4095 is written (4096 cycles), go to LOAD. Counter is ADDR_WIDTH wide; it terminates on all-ones and never wraps.
- LOAD: load_wr=1 writes load_data to load_addr in that cycle. load_done=1 moves to READY next cycle. load_wr and load_done together: the write completes, then the state moves to READY.
- READY: mem_ready=1.
  - ifu_rd_req=1 at posedge N: ifu_rd_data = mem[ifu_rd_addr] after posedge N, so it is stable for the negedge sampling that follows.
  - exec_rd_req behaves identically, on an independent read port.
  - Read data holds its last value when no request is active.
  - exec_wr_req=1 at posedge N: mem[exec_wr_addr] updated at posedge N.
- Simultaneous events:
  - ifu and exec reads in the same cycle: both serviced, same latency.
  - Read and write to the same address in the same cycle: the read returns the OLD value (read-before-write). The new value is visible from the next request.
  - Two reads of the same address: both return the same word.
- Any ifu_rd_req, exec_rd_req or exec_wr_req outside READY: ignored (no array access, read data unchanged) and req_err set. req_err clears only on reset.
- Reset mid-INIT or mid-LOAD: restart from INIT. Partial contents are irrelevant because they are re-cleared.
- Address and data are full width; there is no bounds checking (the address space is exactly 4096 words).

Decomposition:
- pdp8_pkg additions: mem_state_e enum {INIT, LOAD, READY}; MEM_DEPTH = 1<<`ADDR_WIDTH. Reuse `ADDR_WIDTH, `DATA_WIDTH and `START_ADDRESS.
- Sub-module pdp8_mem_array: 2-read/1-write synchronous RAM with read-before-write, registered read outputs and per-port read enables.
- The top level holds the FSM, the clear counter, the write-port mux (INIT clear / LOAD / EXEC) and req_err.

Test Plan:
1. Reset, CLEAR_ON_RESET=1 -> mem_ready=0 for 4096+ cycles. Then in LOAD, load_done with no writes, then ifu_rd_req at address 12'o200 -> ifu_rd_data=0.
2. LOAD writes 12'o200=12'o7001 and 12'o201=12'o1205, then load_done -> fetch 12'o200 returns 7001 (octal) after one posedge; fetch 12'o201 returns 1205 (octal).
3. READY: exec_wr_req to 12'o300 with 12'o0017 and exec_rd_req to 12'o300 in the same cycle -> exec_rd_data = old value 0. Read again next cycle -> 12'o0017.
4. READY: ifu_rd_req at 12'o200 and exec_rd_req at 12'o201 in the same cycle -> both data values correct on the next posedge, with no req_err.
5. ifu_rd_req asserted during INIT -> req_err=1, ifu_rd_data stays 0, array unchanged. req_err stays 1 until reset.
6. Reset pulsed while in LOAD after writing 12'o200=12'o7402 -> re-enters INIT. After a fresh load_done, fetch 12'o200 returns 0.

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 widths, the memory-unit state encoding and the array depth.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef START_ADDRESS
`define START_ADDRESS 12'o200
`endif

package pdp8_pkg;
  localparam int AW        = `ADDR_WIDTH;
  localparam int DW        = `DATA_WIDTH;
  localparam int MEM_DEPTH = 1 << `ADDR_WIDTH;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } mem_state_e;
endpackage

// File: rtl/pdp8_mem_unit_if.sv
// Loader, IFD fetch and EXEC operand buses between the core side and the memory unit.
interface pdp8_mem_unit_if;
  import pdp8_pkg::*;

  logic          load_wr;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_done;
  logic          mem_ready;
  logic          ifu_rd_req;
  logic [AW-1:0] ifu_rd_addr;
  logic [DW-1:0] ifu_rd_data;
  logic          exec_rd_req;
  logic [AW-1:0] exec_rd_addr;
  logic [DW-1:0] exec_rd_data;
  logic          exec_wr_req;
  logic [AW-1:0] exec_wr_addr;
  logic [DW-1:0] exec_wr_data;
  logic          req_err;

  modport master (
    output load_wr, load_addr, load_data, load_done,
    output ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
    output exec_wr_req, exec_wr_addr, exec_wr_data,
    input  mem_ready, ifu_rd_data, exec_rd_data, req_err
  );

  modport slave (
    input  load_wr, load_addr, load_data, load_done,
    input  ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
    input  exec_wr_req, exec_wr_addr, exec_wr_data,
    output mem_ready, ifu_rd_data, exec_rd_data, req_err
  );
endinterface

// File: rtl/pdp8_mem_array.sv
// 2-read/1-write synchronous word store; reads register the pre-write contents
// and hold their last value while their enable is low.
module pdp8_mem_array #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd0_en,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic [DATA_WIDTH-1:0] rd0_data,
  input  logic                  rd1_en,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic [DATA_WIDTH-1:0] rd1_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output registers are reset (active-high reset_n); the store itself is not.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      rd0_data <= '0;
      rd1_data <= '0;
    end else begin
      if (rd0_en) rd0_data <= mem[rd0_addr];
      if (rd1_en) rd1_data <= mem[rd1_addr];
    end
  end
endmodule

// File: rtl/pdp8_mem_unit.sv
// PDP-8 memory responder: clears the store after reset, accepts a loader image,
// then serves IFD fetches and EXEC reads/writes; early requests set sticky req_err.
module pdp8_mem_unit
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  pdp8_mem_unit_if.slave  bus
);
  localparam mem_state_e RST_STATE = CLEAR_ON_RESET ? INIT : LOAD;

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  clr_last;
  logic                  ready;
  logic                  any_req;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  assign clr_last = (clr_cnt_q == '1);
  assign ready    = (state_q == READY);
  assign any_req  = bus.ifu_rd_req | bus.exec_rd_req | bus.exec_wr_req;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state_q <= RST_STATE;
    else         state_q <= state_d;
  end

  // Next state and write-port mux: clear sweep, loader, then EXEC writes.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_addr = clr_cnt_q;
    wr_data = '0;
    case (state_q)
      INIT: begin
        wr_en = 1'b1;
        if (clr_last) state_d = LOAD;
      end
      LOAD: begin
        wr_en   = bus.load_wr;
        wr_addr = bus.load_addr;
        wr_data = bus.load_data;
        if (bus.load_done) state_d = READY;
      end
      READY: begin
        wr_en   = bus.exec_wr_req;
        wr_addr = bus.exec_wr_addr;
        wr_data = bus.exec_wr_data;
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Sweep counter parks on all-ones so the last address is written exactly once.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)                           clr_cnt_q <= '0;
    else if (state_q == INIT && !clr_last) clr_cnt_q <= clr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)             bus.req_err <= 1'b0;
    else if (!ready && any_req) bus.req_err <= 1'b1;
  end

  assign bus.mem_ready = ready;

  pdp8_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd0_en   (ready & bus.ifu_rd_req),
    .rd0_addr (bus.ifu_rd_addr),
    .rd0_data (bus.ifu_rd_data),
    .rd1_en   (ready & bus.exec_rd_req),
    .rd1_addr (bus.exec_rd_addr),
    .rd1_data (bus.exec_rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );
endmodule

// File: tb/tb_pdp8_mem_unit.sv
// Directed bench for pdp8_mem_unit: clear sweep, loader, READY read/write ordering, req_err.
module tb_pdp8_mem_unit;
  logic clk;
  logic reset_n;
  int   vecs;
  int   errs;

  pdp8_mem_unit_if bus ();

  pdp8_mem_unit #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at negedge, the DUT captures at posedge, outputs are read at the next negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset_n          = 1'b1;
    bus.load_wr      = 1'b0;
    bus.load_addr    = '0;
    bus.load_data    = '0;
    bus.load_done    = 1'b0;
    bus.ifu_rd_req   = 1'b0;
    bus.ifu_rd_addr  = '0;
    bus.exec_rd_req  = 1'b0;
    bus.exec_rd_addr = '0;
    bus.exec_wr_req  = 1'b0;
    bus.exec_wr_addr = '0;
    bus.exec_wr_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_ready", {11'd0, bus.mem_ready}, 12'o0);
    chk("rst_ifu_data", bus.ifu_rd_data, 12'o0);
    chk("rst_exec_data", bus.exec_rd_data, 12'o0);
    chk("rst_req_err", {11'd0, bus.req_err}, 12'o0);

    // Phase A: fetch during INIT, early load_done, empty image.
    reset_n = 1'b0;
    bus.ifu_rd_req  = 1'b1;
    bus.ifu_rd_addr = 12'o200;
    cyc();
    bus.ifu_rd_req = 1'b0;
    chk("init_req_err", {11'd0, bus.req_err}, 12'o1);
    chk("init_ifu_data", bus.ifu_rd_data, 12'o0);
    chk("init_mem_ready", {11'd0, bus.mem_ready}, 12'o0);
    repeat (4094) cyc();
    chk("init_late_ready", {11'd0, bus.mem_ready}, 12'o0);
    bus.load_done = 1'b1;
    cyc();
    bus.load_done = 1'b0;
    chk("early_done_ignored", {11'd0, bus.mem_ready}, 12'o0);
    bus.load_done = 1'b1;
    cyc();
    bus.load_done = 1'b0;
    chk("ready_after_done", {11'd0, bus.mem_ready}, 12'o1);
    chk("req_err_sticky", {11'd0, bus.req_err}, 12'o1);
    bus.ifu_rd_req   = 1'b1;
    bus.ifu_rd_addr  = 12'o200;
    bus.exec_rd_req  = 1'b1;
    bus.exec_rd_addr = 12'o7777;
    cyc();
    chk("clr_ifu_200", bus.ifu_rd_data, 12'o0);
    chk("clr_exec_7777", bus.exec_rd_data, 12'o0);
    bus.ifu_rd_addr = 12'o0000;
    bus.exec_rd_req = 1'b0;
    cyc();
    bus.ifu_rd_req = 1'b0;
    chk("clr_ifu_0000", bus.ifu_rd_data, 12'o0);

    // Phase B: program image then READY traffic.
    reset_n = 1'b1;
    cyc();
    chk("rst2_req_err", {11'd0, bus.req_err}, 12'o0);
    chk("rst2_mem_ready", {11'd0, bus.mem_ready}, 12'o0);
    reset_n = 1'b0;
    repeat (4096) cyc();
    bus.load_wr   = 1'b1;
    bus.load_addr = 12'o200;
    bus.load_data = 12'o7001;
    cyc();
    bus.load_addr = 12'o201;
    bus.load_data = 12'o1205;
    cyc();
    bus.load_addr = 12'o202;
    bus.load_data = 12'o5200;
    bus.load_done = 1'b1;
    cyc();
    bus.load_wr   = 1'b0;
    bus.load_done = 1'b0;
    chk("load_ready", {11'd0, bus.mem_ready}, 12'o1);
    bus.ifu_rd_req  = 1'b1;
    bus.ifu_rd_addr = 12'o200;
    cyc();
    chk("fetch_200", bus.ifu_rd_data, 12'o7001);
    bus.ifu_rd_addr = 12'o201;
    cyc();
    chk("fetch_201", bus.ifu_rd_data, 12'o1205);
    bus.ifu_rd_req   = 1'b0;
    bus.exec_rd_req  = 1'b1;
    bus.exec_rd_addr = 12'o202;
    cyc();
    chk("exec_rd_202_wr_with_done", bus.exec_rd_data, 12'o5200);

    bus.exec_wr_req  = 1'b1;
    bus.exec_wr_addr = 12'o300;
    bus.exec_wr_data = 12'o0017;
    bus.exec_rd_addr = 12'o300;
    bus.ifu_rd_req   = 1'b1;
    bus.ifu_rd_addr  = 12'o300;
    cyc();
    bus.exec_wr_req = 1'b0;
    chk("rbw_exec_old", bus.exec_rd_data, 12'o0);
    chk("rbw_ifu_old", bus.ifu_rd_data, 12'o0);
    cyc();
    chk("rbw_exec_new", bus.exec_rd_data, 12'o0017);
    chk("rbw_ifu_new", bus.ifu_rd_data, 12'o0017);

    bus.ifu_rd_addr  = 12'o200;
    bus.exec_rd_addr = 12'o201;
    cyc();
    bus.ifu_rd_req  = 1'b0;
    bus.exec_rd_req = 1'b0;
    chk("dual_ifu_200", bus.ifu_rd_data, 12'o7001);
    chk("dual_exec_201", bus.exec_rd_data, 12'o1205);
    bus.ifu_rd_addr  = 12'o300;
    bus.exec_rd_addr = 12'o300;
    cyc();
    chk("hold_ifu", bus.ifu_rd_data, 12'o7001);
    chk("hold_exec", bus.exec_rd_data, 12'o1205);
    chk("ready_no_req_err", {11'd0, bus.req_err}, 12'o0);

    // Phase C: reset in LOAD discards the partial image; LOAD-time EXEC write ignored.
    reset_n = 1'b1;
    cyc();
    reset_n = 1'b0;
    repeat (4096) cyc();
    bus.load_wr   = 1'b1;
    bus.load_addr = 12'o200;
    bus.load_data = 12'o7402;
    cyc();
    bus.load_wr = 1'b0;
    reset_n = 1'b1;
    cyc();
    chk("mid_load_rst_ready", {11'd0, bus.mem_ready}, 12'o0);
    reset_n = 1'b0;
    repeat (4096) cyc();
    bus.load_wr   = 1'b1;
    bus.load_addr = 12'o220;
    bus.load_data = 12'o3333;
    cyc();
    bus.load_wr      = 1'b0;
    bus.exec_wr_req  = 1'b1;
    bus.exec_wr_addr = 12'o210;
    bus.exec_wr_data = 12'o4444;
    cyc();
    bus.exec_wr_req = 1'b0;
    chk("load_exec_wr_req_err", {11'd0, bus.req_err}, 12'o1);
    bus.load_done = 1'b1;
    cyc();
    bus.load_done    = 1'b0;
    bus.ifu_rd_req   = 1'b1;
    bus.ifu_rd_addr  = 12'o220;
    bus.exec_rd_req  = 1'b1;
    bus.exec_rd_addr = 12'o220;
    cyc();
    chk("reload_ifu_220", bus.ifu_rd_data, 12'o3333);
    chk("reload_exec_220", bus.exec_rd_data, 12'o3333);
    bus.ifu_rd_addr  = 12'o200;
    bus.exec_rd_addr = 12'o210;
    cyc();
    bus.ifu_rd_req  = 1'b0;
    bus.exec_rd_req = 1'b0;
    chk("reload_ifu_200_cleared", bus.ifu_rd_data, 12'o0);
    chk("exec_wr_in_load_ignored", bus.exec_rd_data, 12'o0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
